// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg : types shared by the UART input path                      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package uart_pkg;
  localparam int UART_DATA_BITS = 8;

  typedef logic [UART_DATA_BITS-1:0] byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;
endpackage
`default_nettype wire

// File: rtl/uart_byte_rx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_byte_rx : 8N1 byte receiver, mid-bit sampling                  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  output logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        byte_ferr
);
  localparam int c_cnt_w = $clog2(2*CLK_PER_HALF_BIT) + 1;
  localparam int c_idx_w = $clog2(UART_DATA_BITS);
  localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLK_PER_HALF_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_full_last = c_cnt_w'(2*CLK_PER_HALF_BIT - 1);
  localparam logic [c_idx_w-1:0] c_last_bit  = c_idx_w'(UART_DATA_BITS - 1);

  rx_state_t          r_state, w_state_next;
  logic [1:0]         r_sync;
  logic               r_rxd_prev;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_next;
  logic [c_idx_w-1:0] r_bit_idx, w_bit_idx_next;
  byte_t              r_shift, w_shift_next;
  logic               w_rxd;

  assign w_rxd     = r_sync[1];
  assign byte_data = r_shift;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync     <= 2'b11;
      r_rxd_prev <= 1'b1;
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_sync     <= {r_sync[0], rxd};
      r_rxd_prev <= w_rxd;
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      r_bit_idx  <= w_bit_idx_next;
      r_shift    <= w_shift_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    byte_ready     = 1'b0;
    byte_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (r_rxd_prev && !w_rxd) w_state_next = START;
      end
      START: begin
        // A start bit that is high again at mid-bit was a glitch
        if (r_cnt == c_half_last) begin
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_state_next   = w_rxd ? IDLE : DATA;
        end
      end
      DATA: begin
        if (r_cnt == c_full_last) begin
          w_cnt_next     = '0;
          w_shift_next   = {w_rxd, r_shift[UART_DATA_BITS-1:1]};
          w_bit_idx_next = r_bit_idx + 1'b1;
          if (r_bit_idx == c_last_bit) w_state_next = STOP;
        end
      end
      STOP: begin
        if (r_cnt == c_full_last) begin
          w_cnt_next   = '0;
          byte_ready   = 1'b1;
          byte_ferr    = !w_rxd;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end
endmodule
`default_nettype wire

// File: rtl/uart_input_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_input_stream : UART receiver feeding a byte FIFO, word/byte    |
// | scan reads with stall, sticky overflow/framing flags. Rev 1.0       |
// +--------------------------------------------------------------------+
module uart_input_stream
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 5208,
  parameter int WORD_BYTES       = 4,
  parameter int DEPTH            = 512,
  parameter bit LITTLE_ENDIAN    = 1'b1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      pc_start,
  input  logic                      rxd,
  input  logic                      scan,
  input  logic                      scan_byte,
  input  logic                      clear_err,
  output logic [8*WORD_BYTES-1:0]   ReadData,
  output logic                      valid,
  output logic                      stall,
  output logic                      overflow,
  output logic                      frame_err,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int c_ptr_w  = $clog2(DEPTH);
  localparam int c_lvl_w  = c_ptr_w + 1;
  localparam int c_data_w = 8*WORD_BYTES;
  localparam logic [c_lvl_w-1:0] c_depth = c_lvl_w'(DEPTH);
  localparam logic [c_lvl_w-1:0] c_word  = c_lvl_w'(WORD_BYTES);
  localparam logic [c_lvl_w-1:0] c_one   = c_lvl_w'(1);

  byte_t                w_byte_data;
  logic                 w_byte_ready, w_byte_ferr, w_rxd_gated;
  byte_t                r_mem [DEPTH];
  logic [c_ptr_w-1:0]   r_wr_ptr, r_rd_ptr;
  logic [c_lvl_w-1:0]   r_level, w_need;
  logic                 w_req, w_accept, w_wr, w_full, w_ov_set, w_fe_set;
  logic [c_data_w-1:0]  w_word, w_rd_data;

  assign w_rxd_gated = pc_start ? rxd : 1'b1;

  uart_byte_rx #(
    .CLK_PER_HALF_BIT (CLK_PER_HALF_BIT)
  ) u_byte_rx (
    .clk        (clk),
    .reset      (reset),
    .rxd        (w_rxd_gated),
    .byte_data  (w_byte_data),
    .byte_ready (w_byte_ready),
    .byte_ferr  (w_byte_ferr)
  );

  assign w_full   = (r_level == c_depth);
  assign w_wr     = w_byte_ready && !w_byte_ferr && !w_full;
  assign w_ov_set = w_byte_ready && !w_byte_ferr && w_full;
  assign w_fe_set = w_byte_ready && w_byte_ferr;
  assign w_req    = scan || scan_byte;
  assign w_need   = scan ? c_word : c_one;
  // Pre-write level only: an arriving byte cannot satisfy a read this cycle
  assign w_accept = w_req && (r_level >= w_need);
  assign stall    = w_req && !w_accept;
  assign level    = r_level;

  generate
    for (genvar k = 0; k < WORD_BYTES; k++) begin : g_rd_bytes
      localparam int c_lane = LITTLE_ENDIAN ? k : (WORD_BYTES - 1 - k);
      assign w_word[8*c_lane +: 8] = r_mem[r_rd_ptr + c_ptr_w'(k)];
    end
  endgenerate

  assign w_rd_data = scan ? w_word : c_data_w'(r_mem[r_rd_ptr]);

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_byte_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      ReadData  <= '0;
      valid     <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      valid <= w_accept;
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_accept) begin
        ReadData <= w_rd_data;
        r_rd_ptr <= r_rd_ptr + w_need[c_ptr_w-1:0];
      end
      r_level   <= r_level + c_lvl_w'(w_wr) - (w_accept ? w_need : '0);
      overflow  <= w_ov_set || (overflow && !clear_err);
      frame_err <= w_fe_set || (frame_err && !clear_err);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_input_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_uart_input_stream : LE and BE instances against a queue model    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_uart_input_stream;
  localparam int H      = 8;
  localparam int WB     = 4;
  localparam int DEPTH  = 8;
  // Posedge (relative to the edge before the start bit is driven) at which a byte lands
  localparam int WR_LAT = 3 + 19*H;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pc_start = 1'b1, rxd = 1'b1, scan = 1'b0, scan_byte = 1'b0, clear_err = 1'b0;
  logic [31:0] rd_le, rd_be;
  logic valid_le, valid_be, stall_le, stall_be, ov_le, ov_be, fe_le, fe_be;
  logic [3:0] lvl_le, lvl_be;

  always #5 clk = ~clk;

  uart_input_stream #(.CLK_PER_HALF_BIT(H), .WORD_BYTES(WB), .DEPTH(DEPTH), .LITTLE_ENDIAN(1'b1)) dut_le (
    .clk(clk), .reset(reset), .pc_start(pc_start), .rxd(rxd), .scan(scan), .scan_byte(scan_byte),
    .clear_err(clear_err), .ReadData(rd_le), .valid(valid_le), .stall(stall_le),
    .overflow(ov_le), .frame_err(fe_le), .level(lvl_le));

  uart_input_stream #(.CLK_PER_HALF_BIT(H), .WORD_BYTES(WB), .DEPTH(DEPTH), .LITTLE_ENDIAN(1'b0)) dut_be (
    .clk(clk), .reset(reset), .pc_start(pc_start), .rxd(rxd), .scan(scan), .scan_byte(scan_byte),
    .clear_err(clear_err), .ReadData(rd_be), .valid(valid_be), .stall(stall_be),
    .overflow(ov_be), .frame_err(fe_be), .level(lvl_be));

  typedef struct {
    int         due;
    logic [7:0] d;
    bit         good;
  } ev_t;

  ev_t         sched[$];
  logic [7:0]  q[$];
  int          cyc = 0, n_cmp = 0, n_fail = 0, m_pre = 0, m_need = 0, rnd = 0;
  bit          chk_on = 0, done = 0, m_valid = 0, m_ov = 0, m_fe = 0, m_set_ov = 0, m_set_fe = 0;
  bit          exp_stall = 0;
  logic [31:0] m_le = '0, m_be = '0;
  logic [7:0]  m_b;
  ev_t         m_ev;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: FIFO as a queue, reads pop bytes, arrivals scheduled by send_byte
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      q.delete();
      sched.delete();
      m_valid = 0; m_le = '0; m_be = '0; m_ov = 0; m_fe = 0;
    end else begin
      m_pre   = q.size();
      m_need  = scan ? WB : 1;
      m_valid = 0;
      if ((scan || scan_byte) && m_pre >= m_need) begin
        m_valid = 1; m_le = '0; m_be = '0;
        for (int k = 0; k < m_need; k++) begin
          m_b = q.pop_front();
          if (scan) begin
            m_le = m_le | (32'(m_b) << (8*k));
            m_be = m_be | (32'(m_b) << (8*(WB-1-k)));
          end else begin
            m_le = 32'(m_b);
            m_be = 32'(m_b);
          end
        end
      end
      m_set_ov = 0; m_set_fe = 0;
      while (sched.size() > 0 && sched[0].due <= cyc) begin
        m_ev = sched.pop_front();
        if (!m_ev.good) m_set_fe = 1;
        else if (m_pre < DEPTH) q.push_back(m_ev.d);
        else m_set_ov = 1;
      end
      m_ov = (m_ov && !clear_err) || m_set_ov;
      m_fe = (m_fe && !clear_err) || m_set_fe;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      if (!reset) begin
        chk("rst_rd_le", rd_le, 0);   chk("rst_rd_be", rd_be, 0);
        chk("rst_valid", valid_le, 0); chk("rst_level", lvl_le, 0);
        chk("rst_ov", ov_be, 0);       chk("rst_fe", fe_be, 0);
      end else begin
        exp_stall = (scan || scan_byte) && (q.size() < (scan ? WB : 1));
        chk("stall_le", stall_le, exp_stall); chk("stall_be", stall_be, exp_stall);
        chk("valid_le", valid_le, m_valid);   chk("valid_be", valid_be, m_valid);
        chk("data_le", rd_le, m_le);          chk("data_be", rd_be, m_be);
        chk("level_le", lvl_le, q.size());    chk("level_be", lvl_be, q.size());
        chk("ov_le", ov_le, m_ov);            chk("ov_be", ov_be, m_ov);
        chk("fe_le", fe_le, m_fe);            chk("fe_be", fe_be, m_fe);
      end
    end
  end

  // gate_from: data bit index from which pc_start is held low (9 = never)
  task automatic send_byte(input logic [7:0] d, input bit stop, input bit clr, input int gate_from);
    logic [9:0] frame;
    logic [7:0] eff;
    int e0, bit_no;
    frame = {stop, d, 1'b0};
    eff = d;
    for (int i = gate_from; i < 8; i++) eff[i] = 1'b1;
    @(posedge clk); #1;
    e0 = cyc;
    sched.push_back('{due: e0 + WR_LAT, d: eff, good: (stop || gate_from <= 8)});
    for (int j = 0; j < 20*H; j++) begin
      bit_no   = j / (2*H);
      rxd      = frame[bit_no];
      pc_start = (bit_no < gate_from + 1);
      if (clr && j == WR_LAT - 1) clear_err = 1'b1;
      if (clr && j == WR_LAT)     clear_err = 1'b0;
      @(posedge clk); #1;
    end
    rxd = 1'b1;
    pc_start = 1'b1;
  endtask

  initial begin
    #1 reset = 1'b0;
    chk_on = 1;
    tick(3);
    reset = 1'b1;
    tick(2);

    send_byte(8'h11, 1, 0, 9); send_byte(8'h22, 1, 0, 9); send_byte(8'h33, 1, 0, 9);
    tick(2);
    chk("lvl3", lvl_le, 3);
    scan = 1'b1;
    tick(1);
    chk("stall_at_3_le", stall_le, 1); chk("stall_at_3_be", stall_be, 1);
    send_byte(8'h44, 1, 0, 9);
    scan = 1'b0;
    tick(1);
    chk("word_le", rd_le, 32'h44332211); chk("word_be", rd_be, 32'h11223344);
    chk("lvl_after_word", lvl_le, 0);

    send_byte(8'hA5, 1, 0, 9); send_byte(8'h5A, 1, 0, 9);
    scan_byte = 1'b1;
    tick(2);
    chk("byte2_le", rd_le, 32'h0000005A); chk("byte2_be", rd_be, 32'h0000005A);
    chk("byte2_valid", valid_le, 1);
    scan_byte = 1'b0;
    tick(1);

    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1, 0, 9);
    tick(2);
    chk("full_lvl", lvl_le, 8); chk("full_ov", ov_le, 1);
    scan = 1'b1; tick(2); scan = 1'b0;
    chk("ov_word_le", rd_le, 32'h08070605); chk("ov_word_be", rd_be, 32'h05060708);
    chk("ov_drain_lvl", lvl_be, 0);
    clear_err = 1'b1; tick(1); clear_err = 1'b0;
    chk("ov_cleared", ov_le, 0);

    for (int i = 0; i < 6; i++) send_byte(8'hB0 + 8'(i), 1, 0, 9);
    scan = 1'b1; tick(1); scan = 1'b0;
    chk("wrap_le", rd_le, 32'hB3B2B1B0); chk("wrap_be", rd_be, 32'hB0B1B2B3);
    scan_byte = 1'b1; tick(2); scan_byte = 1'b0;
    chk("wrap_byte", rd_le, 32'h000000B5);

    send_byte(8'h77, 0, 0, 9);
    tick(1);
    chk("fe_set", fe_le, 1); chk("fe_lvl", lvl_le, 0);
    send_byte(8'h66, 0, 1, 9);
    chk("fe_set_wins", fe_be, 1);
    clear_err = 1'b1; tick(1); clear_err = 1'b0;
    chk("fe_cleared", fe_le, 0);

    send_byte(8'hC3, 1, 0, 4);
    scan_byte = 1'b1; tick(1); scan_byte = 1'b0;
    chk("gated_byte", rd_le, 32'h000000F3); chk("gated_no_fe", fe_le, 0);

    @(posedge clk); #1;
    rxd = 1'b0;
    tick(5*H);
    reset = 1'b0; rxd = 1'b1;
    tick(1);
    chk("midrst_data", rd_le, 0); chk("midrst_lvl", lvl_le, 0);
    tick(2);
    reset = 1'b1;
    tick(2);
    send_byte(8'h3C, 1, 0, 9);
    scan_byte = 1'b1; tick(1); scan_byte = 1'b0;
    chk("post_rst_byte", rd_le, 32'h0000003C);

    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send_byte(8'($urandom_range(0, 255)), 1, 0, 9);
          tick($urandom_range(0, 12));
        end
        done = 1;
      end
      begin
        while (!done) begin
          rnd       = $urandom_range(0, 255);
          scan      = (rnd < 40);
          scan_byte = (rnd == 40);
          clear_err = ($urandom_range(0, 31) == 0);
          tick(1);
        end
        scan = 1'b0; scan_byte = 1'b0; clear_err = 1'b0;
      end
    join

    tick(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/uart_input_stream.md
Name: uart_input_stream

Overview:
- Parametrised successor to the core's UART input path: receives serial bytes on rxd and buffers them in a byte-granular FIFO.
- Serves scan reads from the core in two modes: full word (WORD_BYTES bytes, configurable endianness) or single byte (zero-extended).
- Adds concurrent write/read, overflow and framing-error reporting, and an occupancy output.
- Sits between the board RX pin and the core's scan/stall interface.

Parameters:
CLK_PER_HALF_BIT, 5208, UART half-bit period in clk cycles; passed to the byte receiver.
WORD_BYTES, 4, bytes per word read; legal range 1..8; read data width is 8*WORD_BYTES.
DEPTH, 512, FIFO capacity in bytes; power of two; must be >= WORD_BYTES.
LITTLE_ENDIAN, 1, 1: first-received byte goes to ReadData[7:0]; 0: first-received byte goes to the MSB byte.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
pc_start  in  1  receive enable; while 0, rxd is forced to idle (1) at the receiver input
rxd  in  1  UART serial input, 8N1
scan  in  1  word read request, level-held until accepted
scan_byte  in  1  byte read request; ignored while scan=1
clear_err  in  1  one-cycle pulse; clears overflow and frame_err
ReadData  out  8*WORD_BYTES  registered read data
valid  out  1  ReadData valid (one-cycle pulse)
stall  out  1  request present but not accepted this cycle
overflow  out  1  sticky: a byte arrived while the FIFO was full
frame_err  out  1  sticky: a byte had a bad stop bit
level  out  $clog2(DEPTH)+1  current FIFO occupancy in bytes

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers, level, ReadData, valid, overflow and frame_err are all cleared to 0.
  - The receiver FSM returns to IDLE; any byte in flight is discarded.
- Receiver sub-module:
  - FSM IDLE -> START -> DATA(8 bits) -> STOP -> IDLE.
  - START: falling edge on synchronised rxd; mid-bit recheck; if rxd is high, return to IDLE (glitch).
  - Samples at mid-bit. Emits byte_ready for one cycle at STOP mid-bit, with byte_ferr = !stop_bit.
  - rxd passes through a 2-flop synchroniser.
- Write:
  - On byte_ready with byte_ferr=0 and level<DEPTH, the byte is written at wr_ptr and wr_ptr advances modulo DEPTH.
  - byte_ready with byte_ferr=1: byte dropped, frame_err set.
  - byte_ready with level==DEPTH: byte dropped, overflow set, FIFO contents unchanged.
- Read request:
  - need = WORD_BYTES when scan=1; need = 1 when scan=0 and scan_byte=1.
  - accept = request & (level >= need), evaluated on the pre-write level. No same-cycle bypass of an incoming byte.
  - stall = request & !accept (combinational).
- Read data:
  - On accept, need bytes are read from rd_ptr with modulo-DEPTH wrap. Assembled per LITTLE_ENDIAN in word mode; zero-extended in byte mode.
  - ReadData is registered; valid=1 the following cycle only. ReadData holds its value otherwise.
  - rd_ptr advances by need, modulo DEPTH.
- Level and concurrency:
  - Simultaneous write and accepted read are both performed in the same cycle.
  - level_next = level + wr - (accept ? need : 0).
  - level never exceeds DEPTH and never underflows.
- Sticky flags:
  - Set on their event; cleared by clear_err.
  - If clear_err and a new event occur in the same cycle, the set wins.
- Sustained read rate: one accepted request per cycle is allowed; back-to-back accepts give back-to-back valid pulses.
- pc_start=0 mid-byte: the receiver sees a constant 1. The byte completes with whatever was sampled, and its stop bit reads 1, so no frame error results from the gating.

Decomposition:
- Shared package uart_pkg holds:
  - rx FSM state enum (IDLE, START, DATA, STOP)
  - UART_DATA_BITS=8
  - the byte_t typedef
- One sub-module, uart_byte_rx:
  - Parameters: CLK_PER_HALF_BIT.
  - Ports: clk, reset, rxd, byte_data[7:0], byte_ready, byte_ferr.
- FIFO storage is a register array inside uart_input_stream, needed for multi-byte unaligned reads with wrap.

Test Plan:
- Send bytes 0x11,0x22,0x33,0x44 with LITTLE_ENDIAN=1, then scan -> one valid, ReadData=0x44332211, level 4->0. Repeat with LITTLE_ENDIAN=0 -> 0x11223344.
- Hold scan with level=3 -> stall=1 each cycle. Fourth byte arrives -> accept on the next cycle, valid one cycle later; no stall once level=4.
- Send 0xA5, 0x5A, then scan_byte for two cycles -> ReadData=0x000000A5 then 0x0000005A; two consecutive valid pulses.
- DEPTH=8: send 9 bytes -> level=8, overflow=1, 9th byte absent from reads. clear_err -> overflow=0.
- Byte with stop bit 0 -> frame_err=1, level unchanged. Simultaneous clear_err and a second bad byte -> frame_err stays 1.
- Fill to 6 bytes with rd_ptr at 6 (DEPTH=8), scan -> bytes read across the wrap in order. Assert reset mid-byte -> all outputs 0, next clean byte received correctly.
